// File: rtl/encoder8to3_req.sv
// rtl/encoder8to3_req.sv - sequential 8-to-3 request encoder with a valid/ready output slot
module encoder8to3_req #(
   parameter int ROUND_ROBIN = 0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       EN,
   input  logic [7:0] D,
   input  logic       READY,
   output logic [2:0] A,
   output logic       VALID,
   output logic [7:0] PEND
);

   logic [7:0] pend_q;
   logic [2:0] a_q;
   logic       valid_q;
   logic [2:0] last_q;

   logic       free;
   logic       any_pend;
   logic [2:0] sel;
   logic [7:0] clr_mask;
   logic [7:0] set_mask;
   logic [7:0] pend_next;

   assign free     = !valid_q || READY;
   assign any_pend = |pend_q;

   // Pick one pending index from the registered PEND only; D this cycle is not visible here.
   always_comb begin
      logic       found;
      logic [2:0] idx;
      sel   = 3'd0;
      found = 1'b0;
      idx   = 3'd0;
      if (ROUND_ROBIN != 0) begin
         // Start just below the last issued index and wrap; LAST itself is tried last.
         for (int k = 1; k <= 8; k++) begin
            idx = last_q - 3'(k);
            if (!found && pend_q[idx]) begin
               sel   = idx;
               found = 1'b1;
            end
         end
      end else begin
         for (int i = 7; i >= 0; i--) begin
            if (!found && pend_q[i]) begin
               sel   = 3'(i);
               found = 1'b1;
            end
         end
      end
   end

   // Drain the issued bit, then merge new requests so a same-edge re-request survives.
   always_comb begin
      clr_mask  = 8'h00;
      set_mask  = EN ? D : 8'h00;
      if (free && any_pend) begin
         clr_mask = 8'b0000_0001 << sel;
      end
      pend_next = (pend_q & ~clr_mask) | set_mask;
   end

   // Slot, pending register and round-robin pointer update.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pend_q  <= 8'h00;
         a_q     <= 3'd0;
         valid_q <= 1'b0;
         last_q  <= 3'd0;
      end else begin
         if (free) begin
            if (any_pend) begin
               a_q     <= sel;
               valid_q <= 1'b1;
               last_q  <= sel;
            end else begin
               valid_q <= 1'b0;
            end
         end
         pend_q <= pend_next;
      end
   end

   assign A     = a_q;
   assign VALID = valid_q;
   assign PEND  = pend_q;

endmodule

// File: tb/tb_encoder8to3_req.sv
// tb/tb_encoder8to3_req.sv - bench for encoder8to3_req, fixed-priority and round-robin instances
module tb_encoder8to3_req;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       EN = 1'b0;
   logic [7:0] D = 8'h00;
   logic       READY = 1'b0;

   logic [2:0] a_fp, a_rr;
   logic       v_fp, v_rr;
   logic [7:0] p_fp, p_rr;

   int checks = 0;
   int errors = 0;
   bit armed  = 1'b0;

   typedef struct packed {
      logic [7:0] pend;
      logic [2:0] a;
      logic       v;
      logic [2:0] last;
   } mstate_t;

   mstate_t m [2];

   encoder8to3_req #(.ROUND_ROBIN(0)) u_fp (
      .CLK(CLK), .RST(RST), .EN(EN), .D(D), .READY(READY),
      .A(a_fp), .VALID(v_fp), .PEND(p_fp)
   );

   encoder8to3_req #(.ROUND_ROBIN(1)) u_rr (
      .CLK(CLK), .RST(RST), .EN(EN), .D(D), .READY(READY),
      .A(a_rr), .VALID(v_rr), .PEND(p_rr)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference: walk the priority order as a list of indices and take the first pending one.
   function automatic mstate_t model_next(input mstate_t s, input bit rr, input logic rst,
                                          input logic en, input logic [7:0] d, input logic rdy);
      mstate_t n;
      int pick;
      int idx;
      n = s;
      if (rst) begin
         n.pend = 8'h00;
         n.a    = 3'd0;
         n.v    = 1'b0;
         n.last = 3'd0;
         return n;
      end
      if (!s.v || rdy) begin
         pick = -1;
         for (int k = 0; k < 8; k++) begin
            idx = rr ? (int'(s.last) + 7 - k) % 8 : 7 - k;
            if (pick < 0 && s.pend[idx]) pick = idx;
         end
         if (pick >= 0) begin
            n.a          = 3'(pick);
            n.v          = 1'b1;
            n.last       = 3'(pick);
            n.pend[pick] = 1'b0;
         end else begin
            n.v = 1'b0;
         end
      end
      if (en) n.pend = n.pend | d;
      return n;
   endfunction

   // Advance the reference for both instances on each rising edge.
   always @(posedge CLK) begin
      m[0] <= model_next(m[0], 1'b0, RST, EN, D, READY);
      m[1] <= model_next(m[1], 1'b1, RST, EN, D, READY);
   end

   // Compare both instances against the reference every cycle once reset has been seen.
   always @(negedge CLK) begin
      if (armed) begin
         chk("fp_a",     {29'd0, a_fp}, {29'd0, m[0].a});
         chk("fp_valid", {31'd0, v_fp}, {31'd0, m[0].v});
         chk("fp_pend",  {24'd0, p_fp}, {24'd0, m[0].pend});
         chk("rr_a",     {29'd0, a_rr}, {29'd0, m[1].a});
         chk("rr_valid", {31'd0, v_rr}, {31'd0, m[1].v});
         chk("rr_pend",  {24'd0, p_rr}, {24'd0, m[1].pend});
      end
   end

   task automatic step();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic drive(input logic rst, input logic en, input logic [7:0] d, input logic rdy);
      RST   = rst;
      EN    = en;
      D     = d;
      READY = rdy;
   endtask

   initial begin
      // Reset state
      drive(1'b1, 1'b1, 8'hFF, 1'b1);
      step();
      armed = 1'b1;
      chk("rst_pend",  {24'd0, p_fp}, 32'h00);
      chk("rst_valid", {31'd0, v_fp}, 32'h0);
      chk("rst_a",     {29'd0, a_fp}, 32'h0);

      // Idle with no requests
      drive(1'b0, 1'b1, 8'h00, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_pend",  {24'd0, p_fp}, 32'h00);
         chk("idle_valid", {31'd0, v_fp}, 32'h0);
         chk("idle_a",     {29'd0, a_fp}, 32'h0);
      end

      // Single request, two-edge latency
      drive(1'b0, 1'b1, 8'h20, 1'b1);
      step();
      chk("single_pend_n", {24'd0, p_fp}, 32'h20);
      chk("single_valid_n", {31'd0, v_fp}, 32'h0);
      D = 8'h00;
      step();
      chk("single_valid_n1", {31'd0, v_fp}, 32'h1);
      chk("single_a_n1",     {29'd0, a_fp}, 32'h5);
      chk("single_pend_n1",  {24'd0, p_fp}, 32'h00);
      step();
      chk("single_valid_n2", {31'd0, v_fp}, 32'h0);

      // Fixed priority burst
      D = 8'hA5;
      step();
      D = 8'h00;
      step();
      chk("fp_seq0", {29'd0, a_fp}, 32'h7);
      step();
      chk("fp_seq1", {29'd0, a_fp}, 32'h5);
      step();
      chk("fp_seq2", {29'd0, a_fp}, 32'h2);
      step();
      chk("fp_seq3", {29'd0, a_fp}, 32'h0);
      chk("fp_seq3_valid", {31'd0, v_fp}, 32'h1);
      step();
      chk("fp_seq_end", {31'd0, v_fp}, 32'h0);

      // Backpressure
      drive(1'b0, 1'b1, 8'h12, 1'b0);
      step();
      D = 8'h00;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("bp_valid", {31'd0, v_fp}, 32'h1);
         chk("bp_a",     {29'd0, a_fp}, 32'h4);
         chk("bp_pend",  {24'd0, p_fp}, 32'h02);
      end
      READY = 1'b1;
      step();
      chk("bp_release_a", {29'd0, a_fp}, 32'h1);
      chk("bp_release_pend", {24'd0, p_fp}, 32'h00);
      step();
      chk("bp_end_valid", {31'd0, v_fp}, 32'h0);

      // Round-robin versus fixed priority under a continuous 0x81 request
      drive(1'b1, 1'b1, 8'h00, 1'b1);
      step();
      drive(1'b0, 1'b1, 8'h81, 1'b1);
      step();
      step();
      chk("rr_a0", {29'd0, a_rr}, 32'h7);
      chk("rrfp_a0", {29'd0, a_fp}, 32'h7);
      step();
      chk("rr_a1", {29'd0, a_rr}, 32'h0);
      chk("rrfp_a1", {29'd0, a_fp}, 32'h7);
      step();
      chk("rr_a2", {29'd0, a_rr}, 32'h7);
      step();
      chk("rr_a3", {29'd0, a_rr}, 32'h0);
      chk("rrfp_a3", {29'd0, a_fp}, 32'h7);

      // EN gating
      drive(1'b1, 1'b1, 8'h00, 1'b1);
      step();
      drive(1'b0, 1'b0, 8'hFF, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("en_gate_pend",  {24'd0, p_fp}, 32'h00);
         chk("en_gate_valid", {31'd0, v_fp}, 32'h0);
      end

      // Reset mid-transfer
      drive(1'b0, 1'b1, 8'h0F, 1'b0);
      step();
      step();
      chk("pre_rst_pend",  {24'd0, p_fp}, 32'h0F);
      chk("pre_rst_valid", {31'd0, v_fp}, 32'h1);
      chk("pre_rst_a",     {29'd0, a_fp}, 32'h3);
      drive(1'b1, 1'b1, 8'h0F, 1'b0);
      step();
      chk("mid_rst_pend",  {24'd0, p_fp}, 32'h00);
      chk("mid_rst_valid", {31'd0, v_fp}, 32'h0);
      chk("mid_rst_a",     {29'd0, a_fp}, 32'h0);
      drive(1'b0, 1'b1, 8'h08, 1'b1);
      step();
      D = 8'h00;
      step();
      chk("post_rst_a",     {29'd0, a_fp}, 32'h3);
      chk("post_rst_valid", {31'd0, v_fp}, 32'h1);

      // Randomized traffic checked by the reference each cycle
      for (int i = 0; i < 2000; i++) begin
         drive($urandom_range(0, 99) == 0,
               $urandom_range(0, 3) != 0,
               8'($urandom & $urandom),
               $urandom_range(0, 2) != 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
